// File: rtl/sd_clk_gen_resp_pkg.sv
// Shared host-controller definitions: register offsets, write types,
// clock-control FSM encodings and the divider half-period decode.
package sd_clk_gen_resp_pkg;

  localparam logic [11:0] REG_CLK_CTRL = 12'h02C;
  localparam logic [11:0] REG_CAPS     = 12'h040;

  localparam logic [2:0] ATTR_SET = 3'h0;
  localparam logic [2:0] ATTR_OVR = 3'h1;
  localparam logic [2:0] ATTR_CLR = 3'h2;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_STABLE = 2'd2;

  localparam logic [7:0] FREQ_SEL_RST = 8'h40;

  typedef struct packed {
    logic [7:0] freq_sel;
    logic       sd_clk_en;
    logic       int_clk_en;
  } clk_ctrl_t;

  // Half period in clk cycles: weight of the highest set bit, minimum 1.
  function automatic logic [7:0] half_period(input logic [7:0] f);
    logic [7:0] h;
    casez (f)
      8'b1???????: h = 8'd128;
      8'b01??????: h = 8'd64;
      8'b001?????: h = 8'd32;
      8'b0001????: h = 8'd16;
      8'b00001???: h = 8'd8;
      8'b000001??: h = 8'd4;
      8'b0000001?: h = 8'd2;
      default:     h = 8'd1;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/sd_clk_gen_resp_divider.sv
// Half-period counter: toggles the SD clock every i_half cycles and
// flags each edge with a one-cycle strobe registered alongside it.
module sd_clk_divider
  import sd_clk_gen_resp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [7:0] i_half,
  output logic       o_sd_clk,
  output logic       o_pos_strb,
  output logic       o_neg_strb
);

  logic [7:0] r_cnt;
  logic       r_sd_clk;
  logic       r_pos_strb;
  logic       r_neg_strb;
  logic       w_term;

  assign w_term = (r_cnt == (i_half - 8'd1));

  // Clear wins over enable so an abort drops the clock low without a strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= 8'd0;
      r_sd_clk   <= 1'b0;
      r_pos_strb <= 1'b0;
      r_neg_strb <= 1'b0;
    end else if (i_clr || !i_en) begin
      r_cnt      <= 8'd0;
      r_sd_clk   <= 1'b0;
      r_pos_strb <= 1'b0;
      r_neg_strb <= 1'b0;
    end else if (w_term) begin
      r_cnt      <= 8'd0;
      r_sd_clk   <= ~r_sd_clk;
      r_pos_strb <= ~r_sd_clk;
      r_neg_strb <= r_sd_clk;
    end else begin
      r_cnt      <= r_cnt + 8'd1;
      r_pos_strb <= 1'b0;
      r_neg_strb <= 1'b0;
    end
  end

  assign o_sd_clk   = r_sd_clk;
  assign o_pos_strb = r_pos_strb;
  assign o_neg_strb = r_neg_strb;

endmodule

// File: rtl/sd_clk_gen_resp.sv
// SD host Clock Control register (02C), Capabilities readback (040),
// internal-clock settle FSM and the divided SD clock output.
module sd_clk_gen_resp
  import sd_clk_gen_resp_pkg::*;
#(
  parameter logic [7:0] BCF_MHZ       = 8'h32,
  parameter int         STABLE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_reg_strb,
  input  logic [11:0]  wr_reg_index,
  input  logic [31:0]  wr_reg_input,
  input  logic [2:0]   reg_attr,
  input  logic [11:0]  rd_reg_index,
  output logic [127:0] rd_reg_output,
  output logic         sd_clk,
  output logic         sd_clk_pos_strb,
  output logic         sd_clk_neg_strb,
  output logic         int_clk_stable,
  output logic [1:0]   o_dbg_state
);

  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);

  clk_ctrl_t     r_ctrl;
  clk_ctrl_t     w_nx_ctrl;
  logic [1:0]    r_state;
  logic [1:0]    w_nx_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_nx_cnt;
  logic          w_wr;
  logic          w_run;
  logic          w_nx_run;
  logic [7:0]    w_half;
  logic          w_unused_wdata;

  // wr_reg_strb is a single-cycle qualifier; the write lands on that clock edge.
  assign w_wr = wr_reg_strb && (wr_reg_index == REG_CLK_CTRL);
  assign w_unused_wdata = ^{wr_reg_input[31:16], wr_reg_input[7:3], wr_reg_input[1]};

  always_comb begin
    w_nx_ctrl = r_ctrl;
    if (w_wr) begin
      case (reg_attr)
        ATTR_SET: begin
          w_nx_ctrl.int_clk_en = r_ctrl.int_clk_en | wr_reg_input[0];
          w_nx_ctrl.sd_clk_en  = r_ctrl.sd_clk_en | wr_reg_input[2];
          if (wr_reg_input[15:8] != 8'h00) w_nx_ctrl.freq_sel = wr_reg_input[15:8];
        end
        ATTR_OVR: begin
          w_nx_ctrl.int_clk_en = wr_reg_input[0];
          w_nx_ctrl.sd_clk_en  = wr_reg_input[2];
          w_nx_ctrl.freq_sel   = wr_reg_input[15:8];
        end
        ATTR_CLR: begin
          w_nx_ctrl.int_clk_en = r_ctrl.int_clk_en & ~wr_reg_input[0];
          w_nx_ctrl.sd_clk_en  = r_ctrl.sd_clk_en & ~wr_reg_input[2];
        end
        default: ;
      endcase
    end
  end

  // A new divide ratio must settle again before the SD clock may restart.
  always_comb begin
    w_nx_state = r_state;
    w_nx_cnt   = r_cnt;
    if (!w_nx_ctrl.int_clk_en) begin
      w_nx_state = ST_OFF;
      w_nx_cnt   = '0;
    end else if ((r_state == ST_OFF) || (w_nx_ctrl.freq_sel != r_ctrl.freq_sel)) begin
      w_nx_state = ST_SETTLE;
      w_nx_cnt   = '0;
    end else begin
      case (r_state)
        ST_SETTLE: begin
          if (r_cnt == TERM) begin
            w_nx_state = ST_STABLE;
            w_nx_cnt   = '0;
          end else begin
            w_nx_cnt = r_cnt + CW'(1);
          end
        end
        ST_STABLE: ;
        default: begin
          w_nx_state = ST_SETTLE;
          w_nx_cnt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ctrl.freq_sel   <= FREQ_SEL_RST;
      r_ctrl.sd_clk_en  <= 1'b0;
      r_ctrl.int_clk_en <= 1'b0;
      r_state           <= ST_OFF;
      r_cnt             <= '0;
    end else begin
      r_ctrl  <= w_nx_ctrl;
      r_state <= w_nx_state;
      r_cnt   <= w_nx_cnt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg_output <= '0;
    end else begin
      case (rd_reg_index)
        REG_CAPS:     rd_reg_output <= {112'b0, BCF_MHZ, 8'b0};
        REG_CLK_CTRL: rd_reg_output <= {112'b0, r_ctrl.freq_sel, 5'b0, r_ctrl.sd_clk_en,
                                        (r_state == ST_STABLE), r_ctrl.int_clk_en};
        default:      rd_reg_output <= '0;
      endcase
    end
  end

  // Counting needs the run condition both before and after this edge.
  assign w_run    = (r_state == ST_STABLE) && r_ctrl.sd_clk_en;
  assign w_nx_run = (w_nx_state == ST_STABLE) && w_nx_ctrl.sd_clk_en;
  assign w_half   = half_period(r_ctrl.freq_sel);

  sd_clk_divider u_div (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_en       (w_run),
    .i_clr      (!w_nx_run),
    .i_half     (w_half),
    .o_sd_clk   (sd_clk),
    .o_pos_strb (sd_clk_pos_strb),
    .o_neg_strb (sd_clk_neg_strb)
  );

  assign int_clk_stable = (r_state == ST_STABLE);
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_sd_clk_gen_resp.sv
// Bench for sd_clk_gen_resp: directed bring-up sequence, then random
// register traffic, all compared every cycle against an edge-count model.
module tb_sd_clk_gen_resp;

  localparam int         ST  = 16;
  localparam logic [7:0] BCF = 8'h32;

  logic         clk;
  logic         reset;
  logic         wr_reg_strb;
  logic [11:0]  wr_reg_index;
  logic [31:0]  wr_reg_input;
  logic [2:0]   reg_attr;
  logic [11:0]  rd_reg_index;
  logic [127:0] rd_reg_output;
  logic         sd_clk;
  logic         sd_clk_pos_strb;
  logic         sd_clk_neg_strb;
  logic         int_clk_stable;
  logic [1:0]   dbg_state;

  sd_clk_gen_resp #(.BCF_MHZ(BCF), .STABLE_CYCLES(ST)) dut (
    .clk             (clk),
    .reset           (reset),
    .wr_reg_strb     (wr_reg_strb),
    .wr_reg_index    (wr_reg_index),
    .wr_reg_input    (wr_reg_input),
    .reg_attr        (reg_attr),
    .rd_reg_index    (rd_reg_index),
    .rd_reg_output   (rd_reg_output),
    .sd_clk          (sd_clk),
    .sd_clk_pos_strb (sd_clk_pos_strb),
    .sd_clk_neg_strb (sd_clk_neg_strb),
    .int_clk_stable  (int_clk_stable),
    .o_dbg_state     (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  int         cyc;
  bit         m_int_en;
  bit         m_sd_en;
  logic [7:0] m_freq;
  int         m_settle_edge;
  int         m_sd_edge;

  logic [127:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int model_half(input logic [7:0] f);
    int h = 1;
    for (int b = 0; b < 8; b++) if (f[b]) h = 1 << b;
    return h;
  endfunction

  function automatic bit model_stable(input int n);
    return m_int_en && ((n - m_settle_edge) >= ST);
  endfunction

  // {sd_clk, pos, neg} after edge n: run starts at the later of settle end and sd enable.
  function automatic logic [2:0] model_sd(input int n);
    logic [2:0] o = 3'b000;
    int r, m, h;
    if (m_int_en && m_sd_en) begin
      r = m_settle_edge + ST;
      if (m_sd_edge > r) r = m_sd_edge;
      if (n >= r) begin
        m = n - r;
        h = model_half(m_freq);
        o[2] = ((m / h) % 2) == 1;
        if (m > 0 && (m % h) == 0) begin
          o[1] = o[2];
          o[0] = !o[2];
        end
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_int_en = 0;
    m_sd_en  = 0;
    m_freq   = 8'h40;
    m_settle_edge = 0;
    m_sd_edge     = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input int n);
    bit old_en, old_sd;
    logic [7:0] old_f;
    if (!(wr_reg_strb && wr_reg_index == 12'h02C && reg_attr <= 3'd2)) return;
    old_en = m_int_en; old_sd = m_sd_en; old_f = m_freq;
    case (reg_attr)
      3'd0: begin
        m_int_en = m_int_en | wr_reg_input[0];
        m_sd_en  = m_sd_en | wr_reg_input[2];
        if (wr_reg_input[15:8] != 0) m_freq = wr_reg_input[15:8];
      end
      3'd1: begin
        m_int_en = wr_reg_input[0];
        m_sd_en  = wr_reg_input[2];
        m_freq   = wr_reg_input[15:8];
      end
      default: begin
        if (wr_reg_input[0]) m_int_en = 0;
        if (wr_reg_input[2]) m_sd_en = 0;
      end
    endcase
    if (m_int_en && (!old_en || m_freq != old_f)) m_settle_edge = n;
    if (m_sd_en && !old_sd) m_sd_edge = n;
  endtask

  // ---------------- driver / scoreboard ----------------
  task automatic tick();
    logic [127:0] e;
    logic [2:0]   s;
    e = '0;
    if (rd_reg_index == 12'h02C)
      e[15:0] = {m_freq, 5'b0, m_sd_en, model_stable(cyc), m_int_en};
    else if (rd_reg_index == 12'h040)
      e[15:8] = BCF;
    exp_q.push_back(e);
    model_write(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    chk("rd_reg_output", rd_reg_output, exp_q.pop_front());
    s = model_sd(cyc);
    chk("sd_clk", sd_clk, s[2]);
    chk("pos_strb", sd_clk_pos_strb, s[1]);
    chk("neg_strb", sd_clk_neg_strb, s[0]);
    chk("strb_excl", sd_clk_pos_strb & sd_clk_neg_strb, 0);
    chk("int_clk_stable", int_clk_stable, model_stable(cyc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input logic [2:0] a, input logic [11:0] idx, input logic [31:0] d);
    wr_reg_strb  = 1'b1;
    reg_attr     = a;
    wr_reg_index = idx;
    wr_reg_input = d;
    tick();
    wr_reg_strb  = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] ftab [8];
    int k;
    logic [2:0] s;
    ftab = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h03, 8'h06, 8'h05};
    n_vec = 0; n_err = 0; cyc = 0;
    wr_reg_strb = 0; wr_reg_index = 0; wr_reg_input = 0; reg_attr = 0;
    rd_reg_index = 12'h02C;
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd", rd_reg_output, 0);
    chk("rst_sd_clk", sd_clk, 0);
    chk("rst_strb", {sd_clk_pos_strb, sd_clk_neg_strb}, 0);
    chk("rst_stable", int_clk_stable, 0);
    @(negedge clk);
    reset = 1'b0;

    // Power-on: overwrite 0x4001, stable after 16 cycles.
    idle(2);
    chk("pwr_rd_before", rd_reg_output, 128'h4000);
    wr(3'd1, 12'h02C, 32'h0000_4001);
    idle(ST - 1);
    chk("settle_not_yet", int_clk_stable, 0);
    idle(1);
    chk("settle_done", int_clk_stable, 1);
    idle(3);
    chk("pwr_rd", rd_reg_output, 128'h4003);

    // Enable SD clock: period 128.
    wr(3'd0, 12'h02C, 32'h0000_0004);
    idle(63);
    chk("first_rise_early", sd_clk, 0);
    idle(1);
    chk("first_rise", sd_clk, 1);
    idle(300);
    chk("en_rd", rd_reg_output, 128'h4007);

    // Speed change while running.
    idle(20);
    wr(3'd1, 12'h02C, 32'h0000_1005);
    chk("chg_low", sd_clk, 0);
    idle(120);

    // Capabilities read.
    rd_reg_index = 12'h040;
    idle(1);
    chk("caps", rd_reg_output, 128'h3200);
    rd_reg_index = 12'h02C;
    idle(40);

    // Clear int_clk_en.
    wr(3'd2, 12'h02C, 32'h0000_0001);
    chk("clr_sd_low", sd_clk, 0);
    chk("clr_stable", int_clk_stable, 0);
    idle(1);
    chk("clr_freq_kept", rd_reg_output[15:8], 8'h10);

    // Restart, then async reset in a high phase.
    wr(3'd1, 12'h02C, 32'h0000_0405);
    k = 0;
    s = model_sd(cyc);
    while (!s[2] && k < 300) begin
      tick();
      s = model_sd(cyc);
      k++;
    end
    chk("pre_reset_high", sd_clk, 1);
    #4 reset = 1'b1;
    #1;
    chk("async_sd_clk", sd_clk, 0);
    chk("async_strb", {sd_clk_pos_strb, sd_clk_neg_strb}, 0);
    chk("async_stable", int_clk_stable, 0);
    chk("async_rd", rd_reg_output, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    idle(1);
    chk("post_rst_rd", rd_reg_output, 128'h4000);
    idle(5);

    // Random register traffic.
    for (int it = 0; it < 80; it++) begin
      logic [31:0] d;
      logic [11:0] idx;
      d = '0;
      d[0] = ($urandom_range(0, 3) != 0);
      d[2] = ($urandom_range(0, 2) != 0);
      d[15:8] = ftab[$urandom_range(0, 7)];
      d[31:16] = 16'($urandom);
      idx = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'h02C;
      case ($urandom_range(0, 3))
        0: rd_reg_index = 12'h040;
        1: rd_reg_index = 12'($urandom);
        default: rd_reg_index = 12'h02C;
      endcase
      wr(3'($urandom_range(0, 4)), idx, d);
      idle($urandom_range(0, 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
